// File: rtl/mem_pkg.sv
// Shared definitions for the 16x8 memory block, its BIST master and benches.
package mem_pkg;

    localparam int MEM_DEPTH      = 16;
    localparam int MEM_WIDTH      = 8;
    localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

    // BIST sequencer states: one request cycle followed by a wait-for-ready phase
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        DONE
    } bist_state_e;

endpackage

// File: rtl/mem_bist_pattern.sv
// Expected-data generator: (seed ^ zero-extended addr), inverted on the second pass.
module mem_bist_pattern #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      seed,
    input  logic                  pass,
    output logic [WIDTH-1:0]      pattern
);

    // Cast both zero-extends a narrow address and truncates a wide one
    always_comb begin
        pattern = (seed ^ WIDTH'(addr)) ^ {WIDTH{pass}};
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Two-pass write/read-compare BIST master for a valid/ready single-port memory.
module mem_bist_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH      = MEM_DEPTH,
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ADDR_WIDTH+1:0] err_count
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int ERR_W = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);

    bist_state_e           state_q, state_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [ERR_W-1:0]      err_q, err_d;

    logic                  err_evt;
    logic                  tmo_hit;
    logic                  last_addr;
    logic [WIDTH-1:0]      pat_cur;
    logic [WIDTH-1:0]      pat_nxt;

    // Pattern for the access in flight (read compare)
    mem_bist_pattern #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_cur (
        .addr    (addr_q),
        .seed    (seed_q),
        .pass    (pass_q),
        .pattern (pat_cur)
    );

    // Pattern for the next request, so wdata is registered alongside valid
    mem_bist_pattern #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_nxt (
        .addr    (addr_d),
        .seed    (seed_d),
        .pass    (pass_d),
        .pattern (pat_nxt)
    );

    assign tmo_hit   = (tmo_q == TMO_LAST);
    assign last_addr = (addr_q == LAST_ADDR);

    // State and output registers; reset aborts a run and discards its results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pass_q      <= 1'b0;
            addr_q      <= '0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            err_q       <= err_d;
        end
    end

    // Seed is pure data, only meaningful after an accepted start
    always_ff @(posedge clk) begin
        seed_q <= seed_d;
    end

    // Next-state: sequencing, timeout and error bookkeeping
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        addr_d      = addr_q;
        tmo_d       = tmo_q;
        seed_d      = seed_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        err_d       = err_q;
        err_evt     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    seed_d      = seed;
                    pass_d      = 1'b0;
                    addr_d      = '0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                    err_d       = '0;
                    state_d     = WR_REQ;
                end
            end
            WR_REQ: begin
                tmo_d   = '0;
                state_d = WR_WAIT;
            end
            RD_REQ: begin
                tmo_d   = '0;
                state_d = RD_WAIT;
            end
            WR_WAIT: begin
                if (ready || tmo_hit) begin
                    err_evt = !ready;
                    if (last_addr) begin
                        addr_d  = '0;
                        state_d = RD_REQ;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = WR_REQ;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RD_WAIT: begin
                if (ready || tmo_hit) begin
                    // A timed-out read has no data to compare; the timeout is the error
                    err_evt = ready ? (rdata != pat_cur) : 1'b1;
                    if (last_addr) begin
                        if (!pass_q) begin
                            pass_d  = 1'b1;
                            addr_d  = '0;
                            state_d = WR_REQ;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_evt) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = addr_q;
            end
            err_d = (&err_q) ? err_q : err_q + 1'b1;
        end
    end

    // Output decode from the next state so every port comes straight from a flop
    always_comb begin
        valid_d = (state_d == WR_REQ) || (state_d == RD_REQ);
        wr_rd_d = (state_d == WR_REQ) || (state_d == WR_WAIT);
        wdata_d = (state_d == WR_REQ) ? pat_nxt : wdata_q;
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        done_d  = (state_d == DONE);
    end

    assign valid     = valid_q;
    assign wr_rd     = wr_rd_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: behavioural memory with fault injection and a scoreboard.
module tb_mem_bist_ctrl;

    localparam int DEPTH = 16;
    localparam int NACC  = 4 * DEPTH;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       valid;
    logic       wr_rd;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ready;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] fail_addr;
    logic [5:0] err_count;

    int checks = 0;
    int errors = 0;

    // Fault-injection knobs, indexed by position in the access stream
    int flip_a   = -1;
    int flip_b   = -1;
    int supp_idx = -1;
    bit supp_all = 1'b0;
    bit tie_ff   = 1'b0;

    logic [12:0] acc_q[$];
    logic [12:0] exp_acc[$];
    logic [7:0]  mem [DEPTH];

    mem_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .valid     (valid),
        .wr_rd     (wr_rd),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Memory: ready and rdata registered one cycle after valid is sampled
    always @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (valid) begin
                if (wr_rd) begin
                    mem[addr] <= wdata;
                end else begin
                    rdata <= (tie_ff ? 8'hFF : mem[addr]) ^
                             {7'd0, (acc_q.size() == flip_a) || (acc_q.size() == flip_b)};
                end
                ready <= !(supp_all || (acc_q.size() == supp_idx));
                acc_q.push_back({wr_rd, addr, wdata});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: walk the W/R/W/R access stream and apply the fault knobs
    task automatic build_model(input logic [7:0] sd, output int lat, output int nerr,
                               output int faddr);
        int  n;
        bit  to;
        bit  bad;
        logic [7:0] pat;
        logic [7:0] rd;
        n = 0; lat = 0; nerr = 0; faddr = 0;
        exp_acc.delete();
        for (int p = 0; p < 2; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    pat = (sd ^ 8'(a)) ^ ((p == 1) ? 8'hFF : 8'h00);
                    to  = supp_all || (n == supp_idx);
                    if (ph == 0) begin
                        exp_acc.push_back({1'b1, 4'(a), pat});
                        bad = to;
                    end else begin
                        exp_acc.push_back({1'b0, 4'(a), 8'h00});
                        rd  = (tie_ff ? 8'hFF : pat) ^ (((n == flip_a) || (n == flip_b)) ? 8'h01 : 8'h00);
                        bad = to || (rd != pat);
                    end
                    lat += to ? 16 : 2;
                    if (bad) begin
                        if (nerr == 0) faddr = a;
                        nerr++;
                    end
                    n++;
                end
            end
        end
        if (nerr > 63) nerr = 63;
    endtask

    task automatic do_run(input logic [7:0] sd, input int stray_at, input string tag);
        int lat, nerr, faddr, cyc;
        logic [12:0] got;
        logic [12:0] mask;
        build_model(sd, lat, nerr, faddr);
        acc_q.delete();
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == stray_at);
            if (cyc == 1) begin
                check({tag, "_busy_c1"}, busy, 1'b1);
                check({tag, "_done_c1"}, done, 1'b0);
            end
            if (done) break;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_fail"}, fail, (nerr != 0));
        check({tag, "_fail_addr"}, fail_addr, faddr);
        check({tag, "_err_count"}, err_count, nerr);
        check({tag, "_nacc"}, acc_q.size(), NACC);
        for (int i = 0; i < exp_acc.size(); i++) begin
            got  = (i < acc_q.size()) ? acc_q[i] : 13'h1FFF;
            mask = exp_acc[i][12] ? 13'h1FFF : 13'h1F00;
            check($sformatf("%s_acc%0d", tag, i), got & mask, exp_acc[i]);
        end
    endtask

    task automatic clear_faults();
        flip_a = -1; flip_b = -1; supp_idx = -1; supp_all = 1'b0; tie_ff = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_wr_rd"}, wr_rd, 1'b0);
        check({tag, "_addr"}, addr, 4'h0);
        check({tag, "_wdata"}, wdata, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_fail"}, fail, 1'b0);
        check({tag, "_fail_addr"}, fail_addr, 4'h0);
        check({tag, "_err_count"}, err_count, 6'h00);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        seed  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean run with the documented seed, plus spot values from the pattern rule
        do_run(8'hA5, -1, "clean_a5");
        check("a5_p0_addr3", acc_q[3], {1'b1, 4'd3, 8'hA6});
        check("a5_p1_addr3", acc_q[35], {1'b1, 4'd3, 8'h59});

        // Start from DONE, with a stray start pulse mid-test
        do_run(8'hA5, 19, "stray_start");

        // Two bit-0 read faults: pass-0 addr 5 and pass-1 addr 9
        flip_a = 16 + 5;
        flip_b = 48 + 9;
        do_run(8'($urandom), -1, "flip");
        check("flip_fail_addr_5", fail_addr, 4'd5);
        check("flip_err_2", err_count, 6'd2);
        clear_faults();

        // Missing ready on the pass-0 write of addr 2
        supp_idx = 2;
        do_run(8'($urandom), -1, "wr_timeout");
        check("wr_timeout_done", done, 1'b1);
        clear_faults();

        // Read data stuck at all-ones
        tie_ff = 1'b1;
        do_run(8'hFF, -1, "tie_ff");
        clear_faults();

        // No ready at all: every access times out and the count saturates
        supp_all = 1'b1;
        do_run(8'($urandom), -1, "no_ready");
        check("no_ready_sat", err_count, 6'h3F);
        clear_faults();

        // Reset at cycle 40 of a failing run
        tie_ff = 1'b1;
        @(negedge clk);
        seed  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        check("pre_rst_fail", fail, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        acc_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle_nacc", acc_q.size(), 0);
        check("post_rst_idle_busy", busy, 1'b0);
        clear_faults();
        do_run(8'h00, -1, "after_rst");

        // A couple of random clean runs
        for (int k = 0; k < 2; k++) begin
            do_run(8'($urandom), -1, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
